asic_cfg_serializer: RTL and testbench
======================================

// Module: asic_cfg_serializer
// PURPOSE
// Next-generation ASIC configuration writer. It shifts a dynamic (DYNCNF) or static (STATCNF) word
// into the ASIC analog front end over a gated serial clock. The bit rate is derived from CLK by an
// internal divider. Word widths, bit order and pre-shift wait are parametrised. A start/busy/done
// handshake, abort, and MISO readback capture are added. Sits between the config register bank and the ASIC pads.
// PARAMETERS
// DYN_WIDTH   16  dynamic word length in bits (>=2)
// STAT_WIDTH  88  static word length in bits (>=2)
// CLK_DIV     8   CLK cycles per serial-clock half period (>=1); bit period T = 2*CLK_DIV CLK cycles
// IDLE_WAIT   60  bit periods waited after start before the first bit (>=1)
// LSB_FIRST   0   0: MSB shifted first; 1: LSB shifted first
// PORTS
// CLK         in   1           system clock, the only clock
// RST_N       in   1           asynchronous active-low reset
// start       in   1           one-CLK request pulse; sampled only in IDLE or DONE
// sel_dyn     in   1           sampled with start: 1 = dynamic word, 0 = static word
// abort       in   1           synchronous abort; returns the block to IDLE
// dynamic_conf in  DYN_WIDTH   dynamic word; latched on accepted start
// static_conf in   STAT_WIDTH  static word; latched on accepted start
// MISO        in   1           ASIC serial return data
// SCLK        out  1           gated serial clock to ASIC; low except during SHIFT
// MOSI        out  1           serial data; changes only while SCLK is low
// SEL         out  1           1 while a dynamic transfer is in WAIT/SHIFT, else 0
// busy        out  1           1 in WAIT and SHIFT
// done        out  1           one-CLK pulse on SHIFT->DONE
// end_config  out  1           level; 1 in DONE, cleared on leaving DONE
// rb_data     out  MAXW        captured MISO bits, MAXW = max(DYN_WIDTH,STAT_WIDTH), right-aligned, zero-filled
// BEHAVIOUR
// Reset (async, any state): IDLE; all outputs 0; rb_data 0; counters and shift registers cleared.
// div_cnt runs 0..2*CLK_DIV-1 only outside IDLE/DONE and restarts at 0 on every state entry.
//   The bit tick is div_cnt==2*CLK_DIV-1.
// FSM states:
//   IDLE: start=1 -> WAIT. Word and sel_dyn latched, width W selected, MOSI=0.
//   WAIT: IDLE_WAIT bit ticks counted -> SHIFT.
//   SHIFT: W bit periods; after the W-th tick -> DONE.
//   DONE: end_config=1, SCLK=0, MOSI holds the last bit. start=1 -> WAIT (new transfer, same rules as IDLE).
// SHIFT timing, per bit period:
//   - MOSI is updated on the CLK edge at div_cnt==0 with the next bit: word[W-1-i] (LSB_FIRST=0) or word[i] (LSB_FIRST=1).
//   - SCLK=0 for div_cnt 0..CLK_DIV-1 and SCLK=1 for CLK_DIV..2*CLK_DIV-1.
//   - MISO is sampled on the CLK edge where div_cnt==CLK_DIV (SCLK rise).
//   - Sampled bits shift into rb_data in the same order MOSI was sent. rb_data is cleared on accepted start.
//   - Exactly W SCLK rising edges per transfer.
// Latency: first SCLK rise is (1 + IDLE_WAIT*2*CLK_DIV + CLK_DIV) CLK cycles after the start-accept edge.
// Handshake:
//   - start is ignored while busy=1.
//   - done pulses exactly once per completed transfer, concurrent with end_config rising.
// abort=1 in WAIT/SHIFT, on the next edge:
//   - State goes to IDLE with SCLK=0, MOSI=0, SEL=0, busy=0.
//   - No done pulse; rb_data keeps the partial capture.
// abort has priority over start. abort in IDLE/DONE moves the block to IDLE, clearing end_config.
// Simultaneous SHIFT-completion tick and abort: abort wins, no done.
// Input words may change freely after start; only the latched copy is shifted.
// Counter widths use $clog2 of the relevant maximum; no wrap occurs within a legal transfer.
// TESTING
// 1. Reset: hold RST_N=0 mid-SHIFT -> all outputs 0 immediately (async); after release the block is in IDLE, no SCLK.
// 2. Dyn, LSB_FIRST=0, CLK_DIV=8, IDLE_WAIT=60, dynamic_conf=16'hA5C3 -> 16 SCLK rises, MOSI 1010_0101_1100_0011, SEL=1, done once.
// 3. Static 88-bit, LSB_FIRST=1, static_conf=88'h1 -> first MOSI bit 1, remaining 87 bits 0, 88 SCLK rises, SEL=0, end_config=1 after.
// 4. Loopback MISO=MOSI, dyn 16'h8001 -> rb_data==16'h8001 zero-extended at done; SCLK period = 16 CLK.
// 5. abort asserted after 5 bits -> SCLK stays low, no done, busy=0 next cycle; start during busy is ignored (bit count unchanged).
// 6. start asserted in DONE with sel_dyn=0 -> end_config clears, new WAIT begins, full static transfer completes.

Source files
------------

// File: rtl/asic_cfg_serializer_if.sv
// Bus between the config register bank / ASIC pads and the config serializer.
// master drives requests and the ASIC return line; slave is the serializer.
interface asic_cfg_serializer_if #(
  parameter int unsigned DYN_WIDTH  = 16,
  parameter int unsigned STAT_WIDTH = 88
);
  localparam int unsigned MAXW = (DYN_WIDTH > STAT_WIDTH) ? DYN_WIDTH : STAT_WIDTH;

  logic                  start;
  logic                  sel_dyn;
  logic                  abort;
  logic [DYN_WIDTH-1:0]  dynamic_conf;
  logic [STAT_WIDTH-1:0] static_conf;
  logic                  MISO;
  logic                  SCLK;
  logic                  MOSI;
  logic                  SEL;
  logic                  busy;
  logic                  done;
  logic                  end_config;
  logic [MAXW-1:0]       rb_data;

  modport master (
    output start, sel_dyn, abort, dynamic_conf, static_conf, MISO,
    input  SCLK, MOSI, SEL, busy, done, end_config, rb_data
  );

  modport slave (
    input  start, sel_dyn, abort, dynamic_conf, static_conf, MISO,
    output SCLK, MOSI, SEL, busy, done, end_config, rb_data
  );
endinterface

// File: rtl/asic_cfg_serializer.sv
// Shifts a latched dynamic or static config word into the ASIC front end over a
// gated, divided serial clock, capturing MISO in parallel. All outputs registered.
module asic_cfg_serializer #(
  parameter int unsigned DYN_WIDTH  = 16,
  parameter int unsigned STAT_WIDTH = 88,
  parameter int unsigned CLK_DIV    = 8,
  parameter int unsigned IDLE_WAIT  = 60,
  parameter bit          LSB_FIRST  = 1'b0
) (
  input logic                  CLK,
  input logic                  RST_N,
  asic_cfg_serializer_if.slave bus
);
  localparam int unsigned MAXW    = (DYN_WIDTH > STAT_WIDTH) ? DYN_WIDTH : STAT_WIDTH;
  localparam int unsigned DIV_W   = $clog2(2 * CLK_DIV);
  localparam int unsigned CNT_MAX = (IDLE_WAIT > MAXW) ? IDLE_WAIT : MAXW;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = $clog2(MAXW);

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;

  state_t           state_q, state_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [MAXW-1:0]  word_q, word_n;
  logic [MAXW-1:0]  rb_q, rb_n;
  logic             sel_q, sel_n;
  logic             sclk_q, sclk_n;
  logic             mosi_q, mosi_n;
  logic             sel_out_q, sel_out_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             end_q, end_n;

  logic             tick;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] bit_idx;

  // State and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      rb_q      <= '0;
      sel_q     <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      sel_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      div_q     <= div_n;
      cnt_q     <= cnt_n;
      word_q    <= word_n;
      rb_q      <= rb_n;
      sel_q     <= sel_n;
      sclk_q    <= sclk_n;
      mosi_q    <= mosi_n;
      sel_out_q <= sel_out_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      end_q     <= end_n;
    end
  end

  // Next-state and next-output logic; cnt_q counts wait ticks, then bits sent
  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    cnt_n   = cnt_q;
    word_n  = word_q;
    sel_n   = sel_q;
    rb_n    = rb_q;
    mosi_n  = mosi_q;
    sclk_n  = 1'b0;
    done_n  = 1'b0;
    tick    = (div_q == DIV_W'(2 * CLK_DIV - 1));
    width   = sel_q ? CNT_W'(DYN_WIDTH) : CNT_W'(STAT_WIDTH);
    bit_idx = LSB_FIRST ? cnt_q : (width - CNT_W'(1) - cnt_q);

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n = WAIT;
          div_n   = '0;
          cnt_n   = '0;
          sel_n   = bus.sel_dyn;
          word_n  = bus.sel_dyn ? MAXW'(bus.dynamic_conf) : MAXW'(bus.static_conf);
          rb_n    = '0;
          mosi_n  = 1'b0;
        end
      end
      WAIT: begin
        div_n = tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          if (cnt_q == CNT_W'(IDLE_WAIT - 1)) begin
            state_n = SHIFT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
      end
      SHIFT: begin
        div_n = tick ? '0 : div_q + DIV_W'(1);
        if (div_q == '0) mosi_n = word_q[IDX_W'(bit_idx)];
        if (div_q >= DIV_W'(CLK_DIV)) sclk_n = 1'b1;
        // Capture on the SCLK rising edge, right-aligned in transmit order
        if (div_q == DIV_W'(CLK_DIV)) begin
          if (LSB_FIRST) begin
            rb_n = rb_q >> 1;
            rb_n[IDX_W'(width - CNT_W'(1))] = bus.MISO;
          end else begin
            rb_n = {rb_q[MAXW-2:0], bus.MISO};
          end
        end
        if (tick) begin
          if (cnt_q == width - CNT_W'(1)) begin
            state_n = DONE;
            cnt_n   = '0;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Abort beats start and transfer completion; partial capture is kept
    if (bus.abort) begin
      state_n = IDLE;
      div_n   = '0;
      cnt_n   = '0;
      word_n  = word_q;
      sel_n   = sel_q;
      rb_n    = rb_q;
      sclk_n  = 1'b0;
      mosi_n  = 1'b0;
      done_n  = 1'b0;
    end

    busy_n    = (state_n == WAIT) || (state_n == SHIFT);
    sel_out_n = busy_n && sel_n;
    end_n     = (state_n == DONE);
  end

  assign bus.SCLK       = sclk_q;
  assign bus.MOSI       = mosi_q;
  assign bus.SEL        = sel_out_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.end_config = end_q;
  assign bus.rb_data    = rb_q;

endmodule

// File: tb/tb_asic_cfg_serializer.sv
// Scoreboard bench: expected MOSI bits and completion records are queued at stimulus
// time; a negedge monitor pops them on each SCLK rise and each done pulse.
module tb_asic_cfg_serializer;
  localparam int unsigned LAT = 1 + 60 * 2 * 8 + 8;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  asic_cfg_serializer_if #(.DYN_WIDTH(16), .STAT_WIDTH(88)) b0 ();
  asic_cfg_serializer_if #(.DYN_WIDTH(16), .STAT_WIDTH(88)) b1 ();

  logic loop0, miso0, loop1, miso1;
  assign b0.MISO = loop0 ? b0.MOSI : miso0;
  assign b1.MISO = loop1 ? b1.MOSI : miso1;

  asic_cfg_serializer #(.DYN_WIDTH(16), .STAT_WIDTH(88), .CLK_DIV(8), .IDLE_WAIT(60),
                        .LSB_FIRST(1'b0)) u_msb (.CLK(CLK), .RST_N(RST_N), .bus(b0));
  asic_cfg_serializer #(.DYN_WIDTH(16), .STAT_WIDTH(88), .CLK_DIV(8), .IDLE_WAIT(60),
                        .LSB_FIRST(1'b1)) u_lsb (.CLK(CLK), .RST_N(RST_N), .bus(b1));

  typedef struct {
    logic [87:0] rb;
    int          nbits;
  } done_exp_t;

  logic      eb[$];
  done_exp_t dq[$];
  logic      exp_sel;
  int        errors = 0;
  int        checks = 0;
  int        cyc = 0;
  int        start_cyc = 0;
  int        last_rise = 0;
  int        rises = 0;
  int        done_cnt = 0;
  logic      prev0 = 1'b0;
  logic      prev1 = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic on_rise(input string who, input logic mosi, input logic sel);
    if (rises == 0) chk({who, " first-rise latency"}, 128'(cyc - start_cyc), 128'(LAT));
    else            chk({who, " SCLK period"}, 128'(cyc - last_rise), 128'd16);
    last_rise = cyc;
    rises++;
    if (eb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected SCLK rise: got rise %0d, expected none", who, rises);
    end else begin
      chk({who, " MOSI bit"}, 128'(mosi), 128'(eb.pop_front()));
      chk({who, " SEL"}, 128'(sel), 128'(exp_sel));
    end
  endtask

  task automatic on_done(input string who, input logic [87:0] rb, input logic endc,
                         input logic bsy);
    done_exp_t d;
    done_cnt++;
    if (dq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected done: got done pulse, expected none", who);
    end else begin
      d = dq.pop_front();
      chk({who, " rb_data"}, 128'(rb), 128'(d.rb));
      chk({who, " SCLK rise count"}, 128'(rises), 128'(d.nbits));
      chk({who, " end_config with done"}, 128'(endc), 128'd1);
      chk({who, " busy with done"}, 128'(bsy), 128'd0);
    end
  endtask

  // Monitor: samples both DUTs on the falling edge
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        if (b0.SCLK && !prev0) on_rise("msb", b0.MOSI, b0.SEL);
        if (b1.SCLK && !prev1) on_rise("lsb", b1.MOSI, b1.SEL);
        if (b0.done) on_done("msb", b0.rb_data, b0.end_config, b0.busy);
        if (b1.done) on_done("lsb", b1.rb_data, b1.end_config, b1.busy);
      end
      prev0 = b0.SCLK;
      prev1 = b1.SCLK;
    end
  end

  task automatic expect_xfer(input logic [87:0] word, input int w, input bit lsb,
                             input logic sel, input logic [87:0] rb, input int nbits,
                             input bit want_done);
    done_exp_t d;
    for (int i = 0; i < nbits; i++) eb.push_back(lsb ? word[i] : word[w-1-i]);
    exp_sel = sel;
    if (want_done) begin
      d.rb    = rb;
      d.nbits = w;
      dq.push_back(d);
    end
  endtask

  // Accepted start; inputs are scrambled afterwards to prove the word was latched
  task automatic pulse_start(input int which, input logic sd, input logic [87:0] word);
    @(negedge CLK);
    rises = 0;
    if (which == 0) begin
      b0.start = 1'b1; b0.sel_dyn = sd; b0.dynamic_conf = word[15:0]; b0.static_conf = word;
    end else begin
      b1.start = 1'b1; b1.sel_dyn = sd; b1.dynamic_conf = word[15:0]; b1.static_conf = word;
    end
    @(negedge CLK);
    start_cyc = cyc;
    b0.start = 1'b0; b1.start = 1'b0;
    b0.dynamic_conf = ~word[15:0]; b0.static_conf = ~word;
    b1.dynamic_conf = ~word[15:0]; b1.static_conf = ~word;
  endtask

  // Start pulse that must be ignored while busy
  task automatic poke_start(input int which, input logic sd);
    @(negedge CLK);
    if (which == 0) begin b0.start = 1'b1; b0.sel_dyn = sd; end
    else            begin b1.start = 1'b1; b1.sel_dyn = sd; end
    @(negedge CLK);
    b0.start = 1'b0; b1.start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = done_cnt;
    int k = 0;
    while (done_cnt == n && k < limit) begin
      @(negedge CLK);
      k++;
    end
    if (done_cnt == n) begin
      checks++;
      errors++;
      $display("FAIL wait_done timeout: got no done in %0d cycles, expected one", limit);
    end
  endtask

  task automatic wait_rises(input int n, input int limit);
    int k = 0;
    while (rises < n && k < limit) begin
      @(negedge CLK);
      k++;
    end
    if (rises < n) begin
      checks++;
      errors++;
      $display("FAIL wait_rises timeout: got %0d rises, expected %0d", rises, n);
    end
  endtask

  logic [87:0] w6;

  initial begin
    RST_N = 1'b0;
    loop0 = 1'b0; miso0 = 1'b0; loop1 = 1'b0; miso1 = 1'b0;
    b0.start = 1'b0; b0.sel_dyn = 1'b0; b0.abort = 1'b0; b0.dynamic_conf = '0; b0.static_conf = '0;
    b1.start = 1'b0; b1.sel_dyn = 1'b0; b1.abort = 1'b0; b1.dynamic_conf = '0; b1.static_conf = '0;
    w6 = 88'h0123_4567_89AB_CDEF_FEDC_BA;
    repeat (3) @(negedge CLK);

    // Reset state
    chk("reset SCLK", 128'(b0.SCLK), 128'd0);
    chk("reset MOSI", 128'(b0.MOSI), 128'd0);
    chk("reset SEL", 128'(b0.SEL), 128'd0);
    chk("reset busy", 128'(b0.busy), 128'd0);
    chk("reset done", 128'(b0.done), 128'd0);
    chk("reset end_config", 128'(b0.end_config), 128'd0);
    chk("reset rb_data", 128'(b0.rb_data), 128'd0);
    chk("reset lsb busy", 128'(b1.busy), 128'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);

    // Dynamic A5C3 MSB first, MISO low; starts while busy are ignored
    expect_xfer(88'hA5C3, 16, 1'b0, 1'b1, 88'h0, 16, 1'b1);
    pulse_start(0, 1'b1, 88'hA5C3);
    chk("busy after start", 128'(b0.busy), 128'd1);
    chk("SEL in WAIT", 128'(b0.SEL), 128'd1);
    repeat (100) @(negedge CLK);
    poke_start(0, 1'b0);
    wait_rises(3, 2000);
    poke_start(0, 1'b0);
    wait_done(2000);

    // Loopback 8001 from DONE
    loop0 = 1'b1;
    expect_xfer(88'h8001, 16, 1'b0, 1'b1, 88'h8001, 16, 1'b1);
    pulse_start(0, 1'b1, 88'h8001);
    wait_done(2000);

    // Abort after 5 bits, loopback keeps partial capture 10100
    expect_xfer(88'hA5C3, 16, 1'b0, 1'b1, 88'h0, 5, 1'b0);
    pulse_start(0, 1'b1, 88'hA5C3);
    repeat (50) @(negedge CLK);
    poke_start(0, 1'b0);
    wait_rises(5, 2000);
    b0.abort = 1'b1;
    @(negedge CLK);
    b0.abort = 1'b0;
    chk("abort busy", 128'(b0.busy), 128'd0);
    chk("abort SCLK", 128'(b0.SCLK), 128'd0);
    chk("abort SEL", 128'(b0.SEL), 128'd0);
    chk("abort MOSI", 128'(b0.MOSI), 128'd0);
    chk("abort done", 128'(b0.done), 128'd0);
    chk("abort rb_data", 128'(b0.rb_data), 128'h14);
    repeat (100) @(negedge CLK);
    chk("abort rise count", 128'(rises), 128'd5);
    chk("abort no done", 128'(dq.size()), 128'd0);

    // Static 88'h1 LSB first, MISO high
    miso1 = 1'b1;
    expect_xfer(88'h1, 88, 1'b1, 1'b0, {88{1'b1}}, 88, 1'b1);
    pulse_start(1, 1'b0, 88'h1);
    wait_done(3000);
    repeat (5) @(negedge CLK);
    chk("static end_config held", 128'(b1.end_config), 128'd1);
    chk("static SCLK in DONE", 128'(b1.SCLK), 128'd0);

    // New static transfer started from DONE, loopback
    loop1 = 1'b1;
    expect_xfer(w6, 88, 1'b1, 1'b0, w6, 88, 1'b1);
    pulse_start(1, 1'b0, w6);
    chk("restart end_config", 128'(b1.end_config), 128'd0);
    chk("restart busy", 128'(b1.busy), 128'd1);
    chk("restart SEL", 128'(b1.SEL), 128'd0);
    wait_done(3000);

    // Async reset mid-SHIFT
    expect_xfer(88'h3C5A, 16, 1'b0, 1'b1, 88'h3C5A, 16, 1'b1);
    pulse_start(0, 1'b1, 88'h3C5A);
    wait_rises(3, 2000);
    #2 RST_N = 1'b0;
    #1;
    chk("async rst SCLK", 128'(b0.SCLK), 128'd0);
    chk("async rst MOSI", 128'(b0.MOSI), 128'd0);
    chk("async rst SEL", 128'(b0.SEL), 128'd0);
    chk("async rst busy", 128'(b0.busy), 128'd0);
    chk("async rst rb_data", 128'(b0.rb_data), 128'd0);
    chk("async rst lsb end_config", 128'(b1.end_config), 128'd0);
    chk("async rst lsb rb_data", 128'(b1.rb_data), 128'd0);
    eb.delete();
    dq.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (50) @(negedge CLK);
    chk("post-reset busy", 128'(b0.busy), 128'd0);
    chk("post-reset rise count", 128'(rises), 128'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
